gpio_ctrl: RTL and testbench

- Register-mapped controller for a bank of NUM_GPIO tristate IO buffers, one per pin: pin output, pin input, and tristate control T (T=1 → high-Z).
- Holds the output and direction registers for the bank.
- Synchronises pin inputs and detects rising edges into maskable pending-interrupt flags.
- Sits on the processor IO bus with single-cycle strobe/ack; drives one level interrupt line.

---
 rtl/gpio_ctrl.sv | 128 ++++++++++++
 tb/tb_gpio_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// Register-mapped controller for a bank of tristate GPIO pins.
// Holds output/direction state, synchronises inputs and flags enabled rising edges.
module gpio_ctrl #(
    parameter int NUM_GPIO    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic                ack,
    output logic [NUM_GPIO-1:0] io_out,
    input  logic [NUM_GPIO-1:0] io_in,
    output logic [NUM_GPIO-1:0] io_t,
    output logic                irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_IEN  = 2'd2;
    localparam logic [1:0] ADDR_PEND = 2'd3;

    logic [NUM_GPIO-1:0] dout_q, dout_d;
    logic [NUM_GPIO-1:0] dir_q, dir_d;
    logic [NUM_GPIO-1:0] ien_q, ien_d;
    logic [NUM_GPIO-1:0] pend_q, pend_d;
    logic [NUM_GPIO-1:0] prev_q, prev_d;
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_GPIO-1:0] sync_d [SYNC_STAGES];
    logic                ack_q, ack_d;
    logic                irq_q, irq_d;
    logic [31:0]         data_out_q, data_out_d;

    logic                wr;
    logic [NUM_GPIO-1:0] wdata;
    logic [NUM_GPIO-1:0] sync;
    logic [NUM_GPIO-1:0] rise;
    logic [NUM_GPIO-1:0] clr;
    logic [31:0]         rd_val;
    logic                unused_bus;

    assign wr         = stb & we;
    assign wdata      = data_in[NUM_GPIO-1:0];
    assign unused_bus = ^data_in;
    assign sync       = sync_q[SYNC_STAGES-1];
    assign rise       = sync & ~prev_q;

    always_comb begin
        sync_d[0] = io_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        clr    = '0;
        if (wr) begin
            case (addr)
                ADDR_DATA: dout_d = wdata;
                ADDR_DIR:  dir_d  = wdata;
                ADDR_IEN:  ien_d  = wdata;
                ADDR_PEND: clr    = wdata;
                default:   ;
            endcase
        end
    end

    // Set is ORed in after the clear so a coincident new edge is never lost.
    always_comb begin
        prev_d = sync;
        pend_d = (pend_q & ~clr) | (rise & ien_q);
        irq_d  = |(pend_q & ien_q);
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_DATA: rd_val[NUM_GPIO-1:0] = sync;
            ADDR_DIR:  rd_val[NUM_GPIO-1:0] = dir_q;
            ADDR_IEN:  rd_val[NUM_GPIO-1:0] = ien_q;
            ADDR_PEND: rd_val[NUM_GPIO-1:0] = pend_q;
            default:   rd_val = '0;
        endcase
        ack_d      = stb;
        data_out_d = stb ? rd_val : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            dir_q      <= '0;
            ien_q      <= '0;
            pend_q     <= '0;
            prev_q     <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= 32'd0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            dout_q     <= dout_d;
            dir_q      <= dir_d;
            ien_q      <= ien_d;
            pend_q     <= pend_d;
            prev_q     <= prev_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign io_out   = dout_q;
    assign io_t     = ~dir_q;
    assign ack      = ack_q;
    assign data_out = data_out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: bus accesses queue expected read data,
// a monitor compares on every ack and also evaluates queued level checks.
module tb_gpio_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    addr = 2'd0;
    logic [31:0]   data_in = 32'd0;
    logic [31:0]   data_out;
    logic          ack;
    logic [N-1:0]  io_out;
    logic [N-1:0]  io_in = '0;
    logic [N-1:0]  io_t;
    logic          irq;

    gpio_ctrl #(.NUM_GPIO(N), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .io_out   (io_out),
        .io_in    (io_in),
        .io_t     (io_t),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        string       name;
    } bus_exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lvl_chk_t;

    bus_exp_t sb[$];
    lvl_chk_t lvl[$];
    int tests = 0;
    int failed = 0;
    logic stb_at_edge = 1'b0;

    always @(posedge clk) stb_at_edge <= stb && !rst;

    always @(negedge clk) begin
        while (lvl.size() > 0) begin
            lvl_chk_t c;
            c = lvl.pop_front();
            tests++;
            if (c.act !== c.exp) begin
                failed++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, c.act, c.exp);
            end
        end
        if (!rst) begin
            if (ack || stb_at_edge) begin
                tests++;
                if (ack !== stb_at_edge) begin
                    failed++;
                    $display("FAIL ack_timing: got %b expected %b", ack, stb_at_edge);
                end
            end
            if (ack === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
                end else begin
                    bus_exp_t e;
                    e = sb.pop_front();
                    if (e.is_rd) begin
                        tests++;
                        if (data_out !== e.data) begin
                            failed++;
                            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, data_out, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
        bus_exp_t x;
        x.is_rd = !w;
        x.data  = e;
        x.name  = nm;
        stb     = 1'b1;
        we      = w;
        addr    = a;
        data_in = d;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 32'd0, "write");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        bus(1'b0, a, 32'd0, e, nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lvl_chk_t c;
        c.name = nm;
        c.act  = act;
        c.exp  = exp;
        lvl.push_back(c);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(2);
        chk("rst_io_t", 32'(io_t), 32'h000000FF);
        chk("rst_io_out", 32'(io_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        rst = 1'b0;
        cyc(1);
        rd(2'd0, 32'h0, "rst_rd_data");
        rd(2'd1, 32'h0, "rst_rd_dir");
        rd(2'd2, 32'h0, "rst_rd_ien");
        rd(2'd3, 32'h0, "rst_rd_pend");

        // Output drive
        wr(2'd1, 32'h0000000F);
        wr(2'd0, 32'hFFFFFFA5);
        chk("drv_io_t", 32'(io_t), 32'h000000F0);
        chk("drv_io_out", 32'(io_out), 32'h000000A5);
        rd(2'd1, 32'h0000000F, "drv_rd_dir");
        rd(2'd0, 32'h0, "drv_rd_data_pins");

        // Input synchroniser latency: io_in sampled first at edge n
        io_in = 8'h3C;
        cyc(1);
        rd(2'd0, 32'h0, "sync_n_plus_1");
        rd(2'd0, 32'h0000003C, "sync_n_plus_2");

        // Rising-edge interrupt on pin 0
        wr(2'd2, 32'h00000001);
        cyc(1);
        io_in = 8'h3D;
        cyc(2);
        rd(2'd3, 32'h0, "pend_before_set");
        chk("irq_before_set", 32'(irq), 32'h0);
        rd(2'd3, 32'h00000001, "pend_after_set");
        chk("irq_after_set", 32'(irq), 32'h1);
        io_in = 8'h3C;
        cyc(4);
        rd(2'd3, 32'h00000001, "pend_fall_ignored");
        wr(2'd3, 32'h00000001);
        cyc(1);
        chk("irq_after_clear", 32'(irq), 32'h0);
        rd(2'd3, 32'h0, "pend_after_clear");

        // Set beats clear on pin 2
        wr(2'd2, 32'h00000004);
        io_in = 8'h38;
        cyc(4);
        io_in = 8'h3C;
        cyc(5);
        rd(2'd3, 32'h00000004, "pend2_set");
        chk("irq_pend2", 32'(irq), 32'h1);
        io_in = 8'h38;
        cyc(4);
        io_in = 8'h3C;
        cyc(2);
        wr(2'd3, 32'h00000004);
        chk("irq_setclr_0", 32'(irq), 32'h1);
        cyc(1);
        chk("irq_setclr_1", 32'(irq), 32'h1);
        rd(2'd3, 32'h00000004, "pend_set_wins");
        wr(2'd3, 32'h00000004);
        cyc(1);
        rd(2'd3, 32'h0, "pend2_cleared");

        // Masking on pin 1
        wr(2'd2, 32'h00000002);
        io_in = 8'h3E;
        cyc(5);
        chk("irq_pin1", 32'(irq), 32'h1);
        rd(2'd3, 32'h00000002, "pend1_set");
        wr(2'd2, 32'h0);
        cyc(1);
        chk("irq_masked", 32'(irq), 32'h0);
        rd(2'd3, 32'h00000002, "pend1_kept");
        rd(2'd2, 32'h0, "ien_zero");
        wr(2'd2, 32'h00000002);
        cyc(1);
        chk("irq_unmasked", 32'(irq), 32'h1);

        // Reset in the middle of an access: this ack is discarded
        stb  = 1'b1;
        we   = 1'b0;
        addr = 2'd1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_data_out", data_out, 32'h0);
        chk("midrst_io_t", 32'(io_t), 32'h000000FF);
        chk("midrst_io_out", 32'(io_out), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        stb = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        rd(2'd1, 32'h0, "post_rst_dir");
        rd(2'd3, 32'h0, "post_rst_pend");
        cyc(2);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
